// File: rtl/mat_result_checker.sv
// mat_result_checker: sweeps MEM_C against a golden memory and reports mismatch count, first failing address and pass/fail; define MAT_CHK_STREAM_EN to add a per-word result stream
module mat_result_checker #(
  parameter int DW    = 22,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] c_rdata,
  input  logic [DW-1:0] g_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic          first_err_vld
`ifdef MAT_CHK_STREAM_EN
  ,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic          out_mis
`endif
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic go, last_rd, drain_cnt, d_vld, p_vld, mis;
  logic [AW-1:0] d_addr, p_addr;
  logic [DW-1:0] p_c, p_g;
  assign go      = start && (state == IDLE || state == DONE);
  assign last_rd = rd_addr == AW'(DEPTH - 1);
  assign mis     = p_vld && (p_c != p_g);
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  // next state and state-decoded outputs; start is only honoured in IDLE/DONE
  always_comb begin
    state_nxt = go ? READ :
                (state == READ && last_rd) ? DRAIN :
                (state == DRAIN && drain_cnt) ? DONE : state;
    rd_en = state == READ;
    busy  = state == READ || state == DRAIN;
    done  = state == DONE;
    pass  = done && err_cnt == '0;
  end
  // read address sweep, stopping at DEPTH-1, plus two-cycle drain timer
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (go) rd_addr <= '0;
      else if (rd_en && !last_rd) rd_addr <= rd_addr + 1'b1;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  // align address with returning read data, then register both words for compare
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      d_vld  <= 1'b0;
      d_addr <= '0;
      p_vld  <= 1'b0;
      p_addr <= '0;
      p_c    <= '0;
      p_g    <= '0;
    end else begin
      d_vld  <= rd_en;
      d_addr <= rd_addr;
      p_vld  <= d_vld;
      p_addr <= d_addr;
      p_c    <= c_rdata;
      p_g    <= g_rdata;
    end
  // mismatch counter (saturating at DEPTH) and first-failure capture
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
    end else if (go) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_vld  <= 1'b0;
    end else if (mis) begin
      if (err_cnt != (AW+1)'(DEPTH)) err_cnt <= err_cnt + 1'b1;
      if (!first_err_vld) begin
        first_err_addr <= p_addr;
        first_err_vld  <= 1'b1;
      end
    end
`ifdef MAT_CHK_STREAM_EN
  // per-word result stream, aligned with the counter update
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_mis  <= 1'b0;
    end else begin
      out_vld  <= p_vld;
      out_data <= p_c;
      out_mis  <= mis;
    end
`endif
endmodule

// File: tb/tb_mat_result_checker.sv
// tb_mat_result_checker: directed self-checking bench for mat_result_checker
module tb_mat_result_checker;
  localparam int DW = 22, AW = 12, DEPTH = 4096;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic rd_en, busy, done, pass, first_err_vld;
  logic [AW-1:0] rd_addr, first_err_addr;
  logic [DW-1:0] c_rdata = '0, g_rdata = '0;
  logic [AW:0] err_cnt;
  logic [DW-1:0] mem_c [DEPTH];
  logic [DW-1:0] mem_g [DEPTH];
  int n_chk = 0, n_err = 0;
  int dc, rc, bad, sv;
`ifdef MAT_CHK_STREAM_EN
  logic out_vld, out_mis;
  logic [DW-1:0] out_data;
`endif

  mat_result_checker #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .c_rdata(c_rdata), .g_rdata(g_rdata), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_vld(first_err_vld)
`ifdef MAT_CHK_STREAM_EN
    , .out_vld(out_vld), .out_data(out_data), .out_mis(out_mis)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) begin
      c_rdata <= mem_c[rd_addr];
      g_rdata <= mem_g[rd_addr];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_equal();
    for (int i = 0; i < DEPTH; i++) begin
      mem_c[i] = DW'(i * 1237 + 77);
      mem_g[i] = mem_c[i];
    end
  endtask

  // called at a negedge; returns done cycle (-1 on timeout), rd_en count, protocol violations, stream pulses
  task automatic sweep(input int mid, output int d, output int r, output int b, output int s);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; r = 0; b = 0; s = 0; d = -1;
    forever begin
      if (rd_en) r++;
      if (rd_en && (rd_addr != AW'(n - 1) || n > DEPTH)) b++;
      if (busy && done) b++;
`ifdef MAT_CHK_STREAM_EN
      if (out_vld) s++;
`endif
      if (done) begin d = n; break; end
      if (n >= 6000) break;
      start = (n == mid);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic chk_sweep(input string tag, input logic [31:0] e_cnt, input logic [31:0] e_addr);
    chk({tag, " done_cycle"}, dc, 4099);
    chk({tag, " rd_cycles"}, rc, DEPTH);
    chk({tag, " protocol"}, bad, 0);
    chk({tag, " err_cnt"}, 32'(err_cnt), e_cnt);
    chk({tag, " first_err_addr"}, 32'(first_err_addr), e_addr);
    chk({tag, " first_err_vld"}, 32'(first_err_vld), 32'(e_cnt != 0));
    chk({tag, " pass"}, 32'(pass), 32'(e_cnt == 0));
`ifdef MAT_CHK_STREAM_EN
    chk({tag, " out_vld_pulses"}, sv, DEPTH);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_en"}, 32'(rd_en), 0);
    chk({tag, " rd_addr"}, 32'(rd_addr), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pass"}, 32'(pass), 0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 0);
    chk({tag, " first_err_addr"}, 32'(first_err_addr), 0);
    chk({tag, " first_err_vld"}, 32'(first_err_vld), 0);
`ifdef MAT_CHK_STREAM_EN
    chk({tag, " out_vld"}, 32'(out_vld), 0);
`endif
  endtask

  initial begin
    fill_equal();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_done", 32'(done), 0);
    sweep(0, dc, rc, bad, sv);
    chk_sweep("equal", 0, 0);
    repeat (3) @(negedge clk);
    chk("done_level", 32'(done), 1);
    chk("busy_in_done", 32'(busy), 0);
    mem_c[100] = mem_c[100] ^ 22'h200000;
    sweep(0, dc, rc, bad, sv);
    chk_sweep("bit21_at_100", 1, 100);
    fill_equal();
    mem_c[0] = ~mem_c[0];
    mem_c[4095] = mem_c[4095] ^ 22'h000001;
    sweep(0, dc, rc, bad, sv);
    chk_sweep("ends", 2, 0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_c[i] = '0;
      mem_g[i] = 22'h3FFFFF;
    end
    sweep(0, dc, rc, bad, sv);
    chk_sweep("all_wrong", DEPTH, 0);
    fill_equal();
    mem_c[100] = mem_c[100] ^ 22'h200000;
    sweep(2000, dc, rc, bad, sv);
    chk_sweep("mid_start", 1, 100);
    for (int i = 0; i < DEPTH; i++) begin
      mem_c[i] = '0;
      mem_g[i] = 22'h3FFFFF;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1499) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    fill_equal();
    mem_c[0] = ~mem_c[0];
    mem_c[4095] = mem_c[4095] ^ 22'h000001;
    sweep(0, dc, rc, bad, sv);
    chk_sweep("after_reset", 2, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
